// File: rtl/sign_resolve_seq_pkg.sv
// tpu_sign_pkg: sign codes and FSM states shared by the sign resolver and its bus
package tpu_sign_pkg;
  typedef logic [1:0] sign_t;
  localparam sign_t SIGN_LT = 2'b00;
  localparam sign_t SIGN_EQ = 2'b01;
  localparam sign_t SIGN_GT = 2'b10;
  localparam sign_t SIGN_ERR = 2'b11;
  typedef enum logic [1:0] {IDLE, SCAN, FLUSH, DONE} sr_state_t;
endpackage

// File: rtl/sign_resolve_seq_if.sv
// sign_resolve_seq_if: start, per-digit sign stream and result bus for sign_resolve_seq
interface sign_resolve_seq_if #(parameter int CNT_WIDTH = 4);
  import tpu_sign_pkg::*;
  logic start;
  sign_t sign_in;
  logic sign_valid;
  logic sign_ready;
  logic busy;
  sign_t result;
  logic result_valid;
  logic [CNT_WIDTH-1:0] decided_idx;
  logic code_err;
  modport master (output start, sign_in, sign_valid, input sign_ready, busy, result, result_valid, decided_idx, code_err);
  modport slave (input start, sign_in, sign_valid, output sign_ready, busy, result, result_valid, decided_idx, code_err);
endinterface

// File: rtl/sign_resolve_seq.sv
// sign_resolve_seq: resolves a whole-word compare from an MSD-first stream of per-digit sign codes
module sign_resolve_seq
  import tpu_sign_pkg::*;
#(
  parameter int NUM_DIGITS = 8,
  parameter int CNT_WIDTH = $clog2(NUM_DIGITS + 1)
) (
  input logic clk,
  input logic reset,
  sign_resolve_seq_if.slave bus
);
  sr_state_t r_state, w_next;
  logic [CNT_WIDTH-1:0] r_cnt, r_idx;
  logic r_resolved, r_err;
  sign_t r_result;
  logic w_hs, w_last, w_start_ok;
  assign bus.sign_ready = (r_state == SCAN) || (r_state == FLUSH);
  assign bus.busy = bus.sign_ready;
  assign bus.result_valid = r_state == DONE;
  assign bus.result = r_result;
  assign bus.decided_idx = r_idx;
  assign bus.code_err = r_err;
  assign w_hs = bus.sign_valid && bus.sign_ready;
  assign w_last = r_cnt == CNT_WIDTH'(NUM_DIGITS - 1);
  assign w_start_ok = bus.start && ((r_state == IDLE) || (r_state == DONE));
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: w_next = bus.start ? SCAN : IDLE;
      SCAN: w_next = !w_hs ? SCAN : w_last ? DONE : (bus.sign_in != SIGN_EQ) ? FLUSH : SCAN;
      FLUSH: w_next = (w_hs && w_last) ? DONE : FLUSH;
      DONE: w_next = bus.start ? SCAN : IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_idx <= '0;
      r_resolved <= 1'b0;
      r_err <= 1'b0;
      r_result <= SIGN_LT;
    end else begin
      r_state <= w_next;
      if (w_start_ok) begin
        r_cnt <= '0;
        r_resolved <= 1'b0;
        r_err <= 1'b0;
        r_result <= SIGN_EQ;
      end else if (w_hs) begin
        r_cnt <= r_cnt + 1'b1;
        if (bus.sign_in == SIGN_ERR) r_err <= 1'b1;
        if (r_state == SCAN && bus.sign_in != SIGN_EQ) begin
          r_result <= bus.sign_in;
          r_idx <= r_cnt;
          r_resolved <= 1'b1;
        end else if (r_state == SCAN && w_last && !r_resolved) begin
          r_idx <= CNT_WIDTH'(NUM_DIGITS);
        end
      end
    end
  end
endmodule

// File: tb/tb_sign_resolve_seq.sv
// tb_sign_resolve_seq: directed self-checking bench for sign_resolve_seq with NUM_DIGITS=4
module tb_sign_resolve_seq;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;
  sign_resolve_seq_if #(.CNT_WIDTH(3)) bus ();
  sign_resolve_seq #(.NUM_DIGITS(4), .CNT_WIDTH(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic dig(input logic [1:0] d, input int stall);
    bus.sign_valid = 1'b0;
    for (int k = 0; k < stall; k++) begin
      bus.sign_in = 2'b11;
      step();
      chk("stall_rv", bus.result_valid, 0);
      chk("stall_ready", bus.sign_ready, 1);
    end
    chk("pre_rv", bus.result_valid, 0);
    chk("pre_busy", bus.busy, 1);
    bus.sign_valid = 1'b1;
    bus.sign_in = d;
    step();
    bus.sign_valid = 1'b0;
  endtask
  task automatic go();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  initial begin
    reset = 1'b1;
    bus.start = 1'b0;
    bus.sign_valid = 1'b0;
    bus.sign_in = 2'b00;
    step();
    step();
    reset = 1'b0;
    chk("rst_ready", bus.sign_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_rv", bus.result_valid, 0);
    chk("rst_idx", bus.decided_idx, 0);
    chk("rst_err", bus.code_err, 0);
    bus.sign_valid = 1'b1;
    bus.sign_in = 2'b11;
    step();
    bus.sign_valid = 1'b0;
    chk("idle_ignore_busy", bus.busy, 0);
    chk("idle_ignore_err", bus.code_err, 0);
    chk("idle_ignore_res", bus.result, 0);
    go();
    chk("t1_busy", bus.busy, 1);
    chk("t1_ready", bus.sign_ready, 1);
    chk("t1_res_init", bus.result, 2'b01);
    dig(2'b01, 0);
    dig(2'b10, 0);
    chk("t1_res_early", bus.result, 2'b10);
    dig(2'b00, 0);
    dig(2'b01, 0);
    chk("t1_rv", bus.result_valid, 1);
    chk("t1_res", bus.result, 2'b10);
    chk("t1_idx", bus.decided_idx, 1);
    chk("t1_err", bus.code_err, 0);
    chk("t1_busy_done", bus.busy, 0);
    chk("t1_ready_done", bus.sign_ready, 0);
    step();
    chk("t1_rv_off", bus.result_valid, 0);
    chk("t1_hold_res", bus.result, 2'b10);
    chk("t1_hold_idx", bus.decided_idx, 1);
    go();
    for (int i = 0; i < 4; i++) dig(2'b01, 0);
    chk("t2_rv", bus.result_valid, 1);
    chk("t2_res", bus.result, 2'b01);
    chk("t2_idx", bus.decided_idx, 4);
    chk("t2_busy", bus.busy, 0);
    step();
    go();
    dig(2'b01, 3);
    dig(2'b01, 3);
    dig(2'b01, 3);
    dig(2'b00, 3);
    chk("t3_rv", bus.result_valid, 1);
    chk("t3_res", bus.result, 2'b00);
    chk("t3_idx", bus.decided_idx, 3);
    step();
    go();
    dig(2'b01, 0);
    dig(2'b11, 0);
    dig(2'b10, 0);
    dig(2'b01, 0);
    chk("t4_rv", bus.result_valid, 1);
    chk("t4_res", bus.result, 2'b11);
    chk("t4_idx", bus.decided_idx, 1);
    chk("t4_err", bus.code_err, 1);
    step();
    step();
    chk("t4_err_sticky", bus.code_err, 1);
    chk("t4_res_hold", bus.result, 2'b11);
    go();
    chk("t4_err_clr", bus.code_err, 0);
    chk("t4_res_clr", bus.result, 2'b01);
    dig(2'b10, 0);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("t5_start_ign_busy", bus.busy, 1);
    chk("t5_start_ign_res", bus.result, 2'b10);
    dig(2'b01, 0);
    dig(2'b01, 0);
    chk("t5_not_done", bus.result_valid, 0);
    dig(2'b01, 0);
    chk("t5_rv", bus.result_valid, 1);
    chk("t5_res", bus.result, 2'b10);
    chk("t5_idx", bus.decided_idx, 0);
    go();
    chk("t5_done_start_rv", bus.result_valid, 0);
    chk("t5_done_start_busy", bus.busy, 1);
    chk("t5_done_start_res", bus.result, 2'b01);
    dig(2'b01, 0);
    dig(2'b10, 0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_ready", bus.sign_ready, 0);
    chk("t6_rst_res", bus.result, 0);
    chk("t6_rst_idx", bus.decided_idx, 0);
    for (int i = 0; i < 4; i++) begin
      bus.sign_valid = 1'b1;
      bus.sign_in = 2'b10;
      step();
      chk("t6_no_rv", bus.result_valid, 0);
    end
    bus.sign_valid = 1'b0;
    go();
    dig(2'b10, 0);
    dig(2'b01, 0);
    dig(2'b01, 0);
    dig(2'b01, 0);
    chk("t6_rv", bus.result_valid, 1);
    chk("t6_res", bus.result, 2'b10);
    chk("t6_idx", bus.decided_idx, 0);
    step();
    chk("t6_rv_off", bus.result_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
